// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared types, note codes and divider lookup for the melody sequencer
package music_pkg;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SOUND, S_GAP} state_t;

  localparam int CODE_W   = 6;
  localparam int DUR_W    = 3;
  localparam int ENTRY_W  = CODE_W + DUR_W;
  localparam int DIV_W    = 20;
  localparam int NOTE_MAX = 36;

  localparam logic [CODE_W-1:0] NOTE_REST = 6'd0;
  localparam logic [CODE_W-1:0] NOTE_END  = 6'd63;

  // Octave-4 semitone frequencies in micro-hertz; higher octaves are exact doublings.
  function automatic longint base_freq_uhz(input int semi);
    case (semi)
      0:       base_freq_uhz = 64'd261625565;
      1:       base_freq_uhz = 64'd277182631;
      2:       base_freq_uhz = 64'd293664768;
      3:       base_freq_uhz = 64'd311126984;
      4:       base_freq_uhz = 64'd329627557;
      5:       base_freq_uhz = 64'd349228231;
      6:       base_freq_uhz = 64'd369994423;
      7:       base_freq_uhz = 64'd391995436;
      8:       base_freq_uhz = 64'd415304698;
      9:       base_freq_uhz = 64'd440000000;
      10:      base_freq_uhz = 64'd466163762;
      11:      base_freq_uhz = 64'd493883301;
      default: base_freq_uhz = 64'd0;
    endcase
  endfunction

  function automatic logic [DIV_W-1:0] note_to_divider(input logic [CODE_W-1:0] code,
                                                       input longint clk_hz);
    int     n;
    longint f;
    longint q;
    n = int'(code);
    if (n == int'(NOTE_REST) || n > NOTE_MAX) return '0;
    n = n - 1;
    f = base_freq_uhz(n % 12) << (n / 12);
    q = (clk_hz * longint'(1000000) + f / longint'(2)) / f;
    return q[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/song_rom.sv
// rtl/song_rom.sv - synchronous-read song ROM of {code, dur} entries
module song_rom
  import music_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter int AW       = $clog2(SONG_LEN) + 1
) (
  input  logic               clk,
  input  logic [AW-1:0]      i_addr,
  output logic [ENTRY_W-1:0] o_data
);

  logic [ENTRY_W-1:0] w_entry;
  logic [ENTRY_W-1:0] r_data;

  // Unlisted or out-of-range addresses read as the end marker.
  always_comb begin
    w_entry = {NOTE_END, 3'd0};
    if (int'(i_addr) < SONG_LEN) begin
      case (int'(i_addr))
        0:       w_entry = {6'd10, 3'd0};
        1:       w_entry = {6'd1,  3'd1};
        2:       w_entry = {6'd0,  3'd0};
        3:       w_entry = {6'd1,  3'd0};
        4:       w_entry = {6'd40, 3'd1};
        5:       w_entry = {6'd36, 3'd0};
        6:       w_entry = {6'd5,  3'd2};
        default: w_entry = {NOTE_END, 3'd0};
      endcase
    end
  end

  always_ff @(posedge clk) r_data <= w_entry;

  assign o_data = r_data;

endmodule

// File: rtl/melody_seq.sv
// rtl/melody_seq.sv - steps a song ROM and drives the pitch divider with registered note values
module melody_seq
  import music_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICKS_PER_BEAT = 12_500_000,
  parameter int GAP_TICKS      = 1_250_000,
  parameter int SONG_LEN       = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  output logic [DIV_W-1:0]  divider,
  output logic [CODE_W-1:0] scale,
  output logic              note_valid,
  output logic              playing,
  output logic              song_done
);

  localparam int TW = $clog2(TICKS_PER_BEAT);
  localparam int IW = $clog2(SONG_LEN) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
  localparam logic [TW-1:0] TICK_GAP  = TW'(TICKS_PER_BEAT - GAP_TICKS - 1);

  function automatic logic [64*DIV_W-1:0] build_div_table();
    logic [64*DIV_W-1:0] t;
    t = '0;
    for (int c = 0; c < 64; c++) t[c*DIV_W +: DIV_W] = note_to_divider(CODE_W'(c), longint'(CLK_HZ));
    return t;
  endfunction

  localparam logic [64*DIV_W-1:0] DIV_TABLE = build_div_table();

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_index, w_index_nxt;
  logic [DUR_W-1:0]    r_beats, w_beats_nxt;
  logic [TW-1:0]       r_ticks, w_ticks_nxt;
  logic [DIV_W-1:0]    r_divider, w_div_nxt;
  logic [CODE_W-1:0]   r_scale, w_scale_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_playing;
  logic                r_done, w_done_nxt;
  logic [ENTRY_W-1:0]  w_rom_q;
  logic [CODE_W-1:0]   w_rom_code;
  logic [DUR_W-1:0]    w_rom_dur;
  logic [DIV_W-1:0]    w_rom_div;
  logic [DIV_W-1:0]    w_note_div;
  logic                w_at_end;

  // Addressed with the next index so the entry is ready during the FETCH cycle itself.
  song_rom #(.SONG_LEN(SONG_LEN), .AW(IW)) u_rom (
    .clk    (clk),
    .i_addr (w_index_nxt),
    .o_data (w_rom_q)
  );

  assign w_rom_code = w_rom_q[ENTRY_W-1 -: CODE_W];
  assign w_rom_dur  = w_rom_q[DUR_W-1:0];
  assign w_rom_div  = DIV_TABLE[w_rom_code*DIV_W +: DIV_W];
  assign w_note_div = DIV_TABLE[r_scale*DIV_W +: DIV_W];
  assign w_at_end   = (w_rom_code == NOTE_END) || (r_index >= IW'(SONG_LEN));

  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_beats_nxt = r_beats;
    w_ticks_nxt = r_ticks;
    w_div_nxt   = '0;
    w_scale_nxt = r_scale;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_index_nxt = '0;
        w_scale_nxt = '0;
        if (play) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_at_end) begin
          w_index_nxt = '0;
          if (!loop_en) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_scale_nxt = '0;
          end
        end else begin
          w_state_nxt = S_SOUND;
          w_beats_nxt = w_rom_dur;
          w_ticks_nxt = '0;
          w_scale_nxt = w_rom_code;
          w_div_nxt   = w_rom_div;
          w_valid_nxt = (w_rom_div != '0);
        end
      end
      S_SOUND: begin
        if (play) begin
          w_div_nxt   = w_note_div;
          w_valid_nxt = (w_note_div != '0);
          if (r_beats == '0 && r_ticks == TICK_GAP) begin
            w_state_nxt = S_GAP;
            w_ticks_nxt = r_ticks + 1'b1;
            w_div_nxt   = '0;
            w_valid_nxt = 1'b0;
          end else if (r_ticks == TICK_LAST) begin
            w_ticks_nxt = '0;
            w_beats_nxt = r_beats - 1'b1;
          end else begin
            w_ticks_nxt = r_ticks + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (play) begin
          if (r_ticks == TICK_LAST) begin
            w_state_nxt = S_FETCH;
            w_index_nxt = r_index + 1'b1;
            w_ticks_nxt = '0;
          end else begin
            w_ticks_nxt = r_ticks + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_index_nxt = '0;
      w_beats_nxt = '0;
      w_ticks_nxt = '0;
      w_div_nxt   = '0;
      w_scale_nxt = '0;
      w_valid_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_beats   <= '0;
      r_ticks   <= '0;
      r_divider <= '0;
      r_scale   <= '0;
      r_valid   <= 1'b0;
      r_playing <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_index   <= w_index_nxt;
      r_beats   <= w_beats_nxt;
      r_ticks   <= w_ticks_nxt;
      r_divider <= w_div_nxt;
      r_scale   <= w_scale_nxt;
      r_valid   <= w_valid_nxt;
      r_playing <= (w_state_nxt != S_IDLE);
      r_done    <= w_done_nxt;
    end
  end

  assign divider    = r_divider;
  assign scale      = r_scale;
  assign note_valid = r_valid;
  assign playing    = r_playing;
  assign song_done  = r_done;

endmodule

// File: tb/tb_melody_seq.sv
// tb/tb_melody_seq.sv - scoreboard bench for melody_seq against a cycle-budget reference model
module tb_melody_seq;

  localparam int TPB = 4;
  localparam int GAP = 1;
  localparam int LEN = 8;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_SOUND = 2;
  localparam int P_GAP   = 3;

  typedef struct {
    int div;
    int scl;
    int nv;
    int pl;
    int done;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_ = 1'b1;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [19:0] divider;
  logic [5:0]  scale;
  logic        note_valid;
  logic        playing;
  logic        song_done;

  int errors = 0;
  int checks = 0;

  exp_t sb[$];
  exp_t mon_e;

  int song_code [LEN] = '{10, 1, 0, 1, 40, 36, 5, 63};
  int song_dur  [LEN] = '{0, 1, 0, 0, 1, 0, 2, 0};

  int m_phase = P_IDLE;
  int m_idx = 0;
  int m_code = 0;
  int m_remain = 0;

  always #5 clk = ~clk;

  melody_seq #(
    .CLK_HZ         (50_000_000),
    .TICKS_PER_BEAT (TPB),
    .GAP_TICKS      (GAP),
    .SONG_LEN       (LEN)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .play       (play),
    .stop       (stop),
    .loop_en    (loop_en),
    .divider    (divider),
    .scale      (scale),
    .note_valid (note_valid),
    .playing    (playing),
    .song_done  (song_done)
  );

  // Equal temperament from A4 = 440 Hz, rounded to the nearest clock count.
  function automatic int exp_div(input int code);
    real f;
    if (code < 1 || code > 36) return 0;
    f = 440.0 * $pow(2.0, (code - 10) / 12.0);
    return $rtoi(50.0e6 / f + 0.5);
  endfunction

  // Advances the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    exp_t e;
    int   d;
    d = 0;
    e.done = 0;
    if (reset_ || stop) begin
      m_phase = P_IDLE;
      m_idx = 0;
      m_code = 0;
      m_remain = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (play) m_phase = P_FETCH;
        P_FETCH: begin
          if (m_idx >= LEN || song_code[m_idx] == 63) begin
            m_idx = 0;
            if (!loop_en) begin
              m_phase = P_IDLE;
              m_code = 0;
              e.done = 1;
            end
          end else begin
            m_code = song_code[m_idx];
            m_remain = (song_dur[m_idx] + 1) * TPB - GAP;
            m_phase = P_SOUND;
            d = exp_div(m_code);
          end
        end
        P_SOUND: if (play) begin
          m_remain--;
          if (m_remain == 0) begin
            m_phase = P_GAP;
            m_remain = GAP;
          end else begin
            d = exp_div(m_code);
          end
        end
        default: if (play) begin
          m_remain--;
          if (m_remain == 0) begin
            m_phase = P_FETCH;
            m_idx++;
          end
        end
      endcase
    end
    e.div = d;
    e.scl = m_code;
    e.nv = (d != 0) ? 1 : 0;
    e.pl = (m_phase != P_IDLE) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic p, input logic s, input logic l, input logic r);
    @(negedge clk);
    play = p;
    stop = s;
    loop_en = l;
    reset_ = r;
    model_step();
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("divider", int'(divider), mon_e.div);
        check("scale", int'(scale), mon_e.scl);
        check("note_valid", int'(note_valid), mon_e.nv);
        check("playing", int'(playing), mon_e.pl);
        check("song_done", int'(song_done), mon_e.done);
      end
    end
  end

  initial begin
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (70) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (60) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (130) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (14) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0), loop_en,
          ($urandom_range(0, 499) == 0));
    end
    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
